ili9341_spi_rx: RTL and testbench
=================================

// Module: ili9341_spi_rx
// PURPOSE
// Panel-side responder for the ILI9341 4-wire SPI link (SCK, CSX, D/CX, SDA): the receiving end of our display driver.
// Oversamples the serial lines in the system clock domain, rebuilds bytes and splits them by D/CX into commands and parameters.
// Packs Memory Write (0x2C) data into RGB565 pixels and tracks sleep/display state.
// Used as the synthesizable panel model in loopback benches and as an on-FPGA protocol monitor.
// PARAMETERS
// SYNC_STAGES  2      flip-flop stages on sck/cs_n/dc/mosi before edge detection (>=2)
// PIX_CNT_W    17     width of pixel counter (320*240 = 76800 fits)
// RAMWR_CMD    8'h2C  command byte that opens the pixel stream
// PORTS
// clk          in   1          system clock; must be >= 4x SCK frequency
// rst          in   1          synchronous active-high reset
// sck          in   1          SPI clock, async to clk, idle low, data sampled on rising edge
// cs_n         in   1          chip select, active low, async
// dc           in   1          D/CX: 0 = command, 1 = parameter/data; captured with bit 0 of each byte
// mosi         in   1          serial data, MSB first
// byte_valid   out  1          1-cycle pulse: byte_data/byte_dc valid
// byte_data    out  8          last completed byte
// byte_dc      out  1          D/CX value captured with that byte
// cmd_valid    out  1          1-cycle pulse on a command byte (dc=0)
// cmd_code     out  8          last command received (held)
// param_valid  out  1          1-cycle pulse on a parameter byte when cmd_code != RAMWR_CMD
// param_idx    out  4          index of that parameter since its command (0-based, saturates at 15)
// pix_valid    out  1          1-cycle pulse: pix_data holds a complete RGB565 pixel
// pix_data     out  16         {first byte, second byte}
// pix_count    out  PIX_CNT_W  pixels since last RAMWR_CMD; saturates at all-ones
// sleep_out    out  1          set by 0x11, cleared by 0x10
// disp_on      out  1          set by 0x29, cleared by 0x28
// BEHAVIOUR
// - Reset: all outputs 0 (cmd_code 8'h00, pix_count 0); bit counter, pixel phase and sync chains cleared.
//   rst wins over any simultaneous SPI event.
// - Sync: each input passes SYNC_STAGES flops; the SCK rise is detected as sync'd sck 0->1.
//   An SCK rise while sync'd cs_n=1 is ignored.
// - Shift: on each detected rise, mosi shifts into an 8-bit register and bit_cnt (0..7) increments.
//   On the 8th rise dc is captured and bit_cnt wraps to 0.
// - Latency: byte_valid asserts on the cycle after the clk edge that detects the 8th rise.
//   That is SYNC_STAGES+2 clk edges after the rise is first registered.
//   cmd_valid, param_valid and pix_valid coincide with byte_valid, never later.
// - Decode states: IDLE (no command yet or non-RAMWR), PARAM (counting params), RAMWR_HI, RAMWR_LO.
//   Any dc=0 byte: cmd_code<=byte, cmd_valid=1, param_idx<=0, pixel phase cleared.
//     To RAMWR_HI (pix_count<=0) if byte==RAMWR_CMD, else to PARAM.
//   PARAM + dc=1: param_valid=1 with current param_idx, then param_idx++ (sat 15).
//   RAMWR_HI + dc=1: hold byte, go RAMWR_LO, no pix_valid.
//   RAMWR_LO + dc=1: pix_valid=1, pix_data={held,byte}, pix_count++ (sat), go RAMWR_HI.
//   dc=1 byte before any command (IDLE): byte_valid only, nothing else.
// - State bits: 0x11/0x10/0x29/0x28 update sleep_out/disp_on in the same cycle as cmd_valid. All other codes leave them.
// - cs_n deassert (sync'd 0->1) mid-byte: partial bits discarded, bit_cnt<=0, no byte_valid.
//   In RAMWR_LO the held byte is dropped and the state returns to RAMWR_HI. cmd_code and state bits are kept.
// - cs_n deassert on the same clk as an 8th-bit rise: byte completes first, then the counter clears.
// - Byte boundaries are defined only by bit_cnt; dc changes mid-byte are irrelevant except at bit 0.
// TESTING
// - Reset mid-byte after 5 bits, then full byte 0x2C dc=0 -> all outputs 0 during reset.
//   Afterwards exactly one cmd_valid, cmd_code=0x2C, no stray pulses.
// - Cmd 0xC5 then params 0x3E, 0x28 -> cmd_valid once; param_valid twice with param_idx 0,1 and bytes 0x3E,0x28.
// - Cmd 0x2C then data F8,00,07,E0 -> pix_valid twice: 0xF800, then 0x07E0; pix_count=2; no param_valid.
// - Cmd 0x2C, send 0xAA, deassert cs_n after 3 bits of next byte, reassert, then send 0x12,0x34.
//   -> exactly one pixel 0x1234; 0xAA and the partial byte dropped.
// - Send 0x11, 0x29, then 0x28 -> sleep_out=1 and disp_on=1 after 0x29; disp_on=0 after 0x28; sleep_out stays 1.
// - SCK at clk/4, back-to-back bytes, byte completion aligned with cs_n rise.
//   -> latency is exactly SYNC_STAGES+2 clk from the 8th registered rise; no byte loss; final byte still reported.

Source files
------------

// File: rtl/ili9341_spi_rx_if.sv
// ILI9341 4-wire serial bus: SCK, CSX, D/CX, SDA.
// master drives the lines, slave (panel side) listens.
interface ili9341_spi_rx_if;
  logic sck;
  logic cs_n;
  logic dc;
  logic mosi;

  modport master (
    output sck,
    output cs_n,
    output dc,
    output mosi
  );

  modport slave (
    input sck,
    input cs_n,
    input dc,
    input mosi
  );
endinterface

// File: rtl/ili9341_spi_rx.sv
// ILI9341 panel-side SPI receiver: byte rebuild,
// command/parameter split, RGB565 packing, state bits.
module ili9341_spi_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter int         PIX_CNT_W   = 17,
  parameter logic [7:0] RAMWR_CMD   = 8'h2C
) (
  input  logic                 clk,
  input  logic                 rst,
  ili9341_spi_rx_if.slave      spi,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  output logic                 byte_dc,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic                 param_valid,
  output logic [3:0]           param_idx,
  output logic                 pix_valid,
  output logic [15:0]          pix_data,
  output logic [PIX_CNT_W-1:0] pix_count,
  output logic                 sleep_out,
  output logic                 disp_on
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARAM,
    S_RAMWR_HI,
    S_RAMWR_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic       sck_s, cs_s, dc_s, mosi_s;
  logic       sck_d, cs_d;
  logic       sck_rise, cs_rise;
  logic       bit_ok, last_bit;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       done_r;
  logic       abort_r;
  logic [7:0] byte_r;
  logic       dc_r;

  state_t     state;
  logic [3:0] pcnt;
  logic [7:0] held;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  // a rise coinciding with the CSX edge still belongs to the frame
  assign bit_ok   = sck_rise & ~(cs_s & cs_d);
  assign last_bit = bit_ok & (bit_cnt == 3'd7);

  // synchronise lines, detect edges, shift bits into bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      dc_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      byte_r    <= 8'h00;
      dc_r      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi.dc};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      if (bit_ok) begin
        shreg   <= {shreg[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (last_bit) begin
        done_r <= 1'b1;
        byte_r <= {shreg[6:0], mosi_s};
        dc_r   <= dc_s;
      end
      if (cs_rise && !last_bit) begin
        bit_cnt <= 3'd0;
        abort_r <= (bit_cnt != 3'd0) || bit_ok;
      end
    end
  end

  // decode completed bytes into commands, params, pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pcnt        <= 4'd0;
      held        <= 8'h00;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      byte_dc     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      param_valid <= 1'b0;
      param_idx   <= 4'd0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'h0000;
      pix_count   <= '0;
      sleep_out   <= 1'b0;
      disp_on     <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      cmd_valid   <= 1'b0;
      param_valid <= 1'b0;
      pix_valid   <= 1'b0;
      if (done_r) begin
        byte_valid <= 1'b1;
        byte_data  <= byte_r;
        byte_dc    <= dc_r;
        unique case (1'b1)
          !dc_r: begin
            cmd_valid <= 1'b1;
            cmd_code  <= byte_r;
            pcnt      <= 4'd0;
            param_idx <= 4'd0;
            if (byte_r == RAMWR_CMD) begin
              state     <= S_RAMWR_HI;
              pix_count <= '0;
            end else begin
              state <= S_PARAM;
            end
            case (byte_r)
              8'h11:   sleep_out <= 1'b1;
              8'h10:   sleep_out <= 1'b0;
              8'h29:   disp_on   <= 1'b1;
              8'h28:   disp_on   <= 1'b0;
              default: ;
            endcase
          end
          dc_r && (state == S_PARAM): begin
            param_valid <= 1'b1;
            param_idx   <= pcnt;
            if (pcnt != 4'd15) pcnt <= pcnt + 4'd1;
          end
          dc_r && (state == S_RAMWR_HI): begin
            held  <= byte_r;
            state <= S_RAMWR_LO;
          end
          dc_r && (state == S_RAMWR_LO): begin
            pix_valid <= 1'b1;
            pix_data  <= {held, byte_r};
            state     <= S_RAMWR_HI;
            if (pix_count != '1)
              pix_count <= pix_count + PIX_CNT_W'(1);
          end
          default: ;
        endcase
      end else if (abort_r && state == S_RAMWR_LO) begin
        state <= S_RAMWR_HI;
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Directed bench for ili9341_spi_rx: SCK at clk/4,
// hand-computed bytes, pixels, indices and latency.
module tb_ili9341_spi_rx;
  localparam int SYNC = 2;
  localparam int PW   = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ili9341_spi_rx_if spi();

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_dc;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic          param_valid;
  logic [3:0]    param_idx;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [PW-1:0] pix_count;
  logic          sleep_out;
  logic          disp_on;

  ili9341_spi_rx #(
    .SYNC_STAGES(SYNC),
    .PIX_CNT_W(PW),
    .RAMWR_CMD(8'h2C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi.slave),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_dc(byte_dc),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .param_valid(param_valid),
    .param_idx(param_idx),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_count(pix_count),
    .sleep_out(sleep_out),
    .disp_on(disp_on)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_bad = 0;
  int n_cmd, n_param, n_pix;

  logic [7:0]  bq[$];
  logic        bdq[$];
  int          bcq[$];
  int          rq[$];
  logic [7:0]  pq[$];
  logic [3:0]  piq[$];
  logic [15:0] xq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if ({byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
           param_valid, param_idx, pix_valid, pix_data, pix_count,
           sleep_out, disp_on} !== '0)
        rst_bad++;
    end
    if (byte_valid === 1'b1) begin
      bq.push_back(byte_data);
      bdq.push_back(byte_dc);
      bcq.push_back(cyc);
    end
    if (cmd_valid === 1'b1) n_cmd++;
    if (param_valid === 1'b1) begin
      n_param++;
      pq.push_back(byte_data);
      piq.push_back(param_idx);
    end
    if (pix_valid === 1'b1) begin
      n_pix++;
      xq.push_back(pix_data);
    end
  end

  task automatic clear_mon();
    bq.delete(); bdq.delete(); bcq.delete(); rq.delete();
    pq.delete(); piq.delete(); xq.delete();
    n_cmd = 0; n_param = 0; n_pix = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi.mosi = b;
    spi.sck  = 1'b0;
    #20;
    spi.sck  = 1'b1;
    #20;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d,
                           input logic cs_hi);
    for (int i = 7; i >= 0; i--) begin
      spi.dc   = d;
      spi.mosi = b[i];
      spi.sck  = 1'b0;
      #20;
      spi.sck  = 1'b1;
      if (i == 0) begin
        rq.push_back(cyc);
        if (cs_hi) spi.cs_n = 1'b1;
      end
      #20;
    end
    spi.sck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spi.sck = 1'b0; spi.cs_n = 1'b1;
    spi.dc = 1'b0; spi.mosi = 1'b0;
    idle(4);
    checks++;
    if ({cmd_code, pix_count, byte_valid, sleep_out, disp_on} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0",
               {cmd_code, pix_count, byte_valid, sleep_out, disp_on});
    end
    rst = 1'b0;
    idle(3);
    spi.cs_n = 1'b0;
    idle(3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    spi.sck = 1'b0;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    clear_mon();
    idle(3);
    send_byte(8'h2C, 1'b0, 1'b0);
    idle(12);
    checks++;
    if (rst_bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: got %0d nonzero samples required 0", rst_bad);
    end
    checks++;
    if (n_cmd !== 1) begin
      errors++;
      $display("FAIL reset_cmd_cnt: got %0d required 1", n_cmd);
    end
    checks++;
    if (cmd_code !== 8'h2C) begin
      errors++;
      $display("FAIL reset_cmd_code: got %0h required 2c", cmd_code);
    end
    checks++;
    if (bq.size() !== 1 || n_param !== 0 || n_pix !== 0) begin
      errors++;
      $display("FAIL reset_stray: got bytes=%0d params=%0d pix=%0d required 1/0/0",
               bq.size(), n_param, n_pix);
    end
  endtask

  task automatic test_params();
    clear_mon();
    send_byte(8'hC5, 1'b0, 1'b0);
    send_byte(8'h3E, 1'b1, 1'b0);
    send_byte(8'h28, 1'b1, 1'b0);
    idle(12);
    checks++;
    if (n_cmd !== 1 || n_param !== 2) begin
      errors++;
      $display("FAIL param_counts: got cmd=%0d param=%0d required 1/2",
               n_cmd, n_param);
    end
    checks++;
    if (piq.size() != 2 || piq[0] !== 4'd0 || piq[1] !== 4'd1) begin
      errors++;
      $display("FAIL param_idx: got %0d entries required idx 0,1", piq.size());
    end
    checks++;
    if (pq.size() != 2 || pq[0] !== 8'h3E || pq[1] !== 8'h28) begin
      errors++;
      $display("FAIL param_data: got %0d entries required 3e,28", pq.size());
    end
    checks++;
    if (cmd_code !== 8'hC5) begin
      errors++;
      $display("FAIL param_cmd_code: got %0h required c5", cmd_code);
    end
  endtask

  task automatic test_pixels();
    clear_mon();
    send_byte(8'h2C, 1'b0, 1'b0);
    send_byte(8'hF8, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h07, 1'b1, 1'b0);
    send_byte(8'hE0, 1'b1, 1'b0);
    idle(12);
    checks++;
    if (n_pix !== 2 || n_param !== 0) begin
      errors++;
      $display("FAIL pix_counts: got pix=%0d param=%0d required 2/0",
               n_pix, n_param);
    end
    checks++;
    if (xq.size() != 2 || xq[0] !== 16'hF800 || xq[1] !== 16'h07E0) begin
      errors++;
      $display("FAIL pix_data: got %0d pixels required f800,07e0", xq.size());
    end
    checks++;
    if (pix_count !== 17'd2) begin
      errors++;
      $display("FAIL pix_count: got %0d required 2", pix_count);
    end
  endtask

  task automatic test_cs_abort();
    clear_mon();
    send_byte(8'h2C, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    spi.dc = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    spi.sck = 1'b0;
    idle(2);
    spi.cs_n = 1'b1;
    idle(8);
    spi.cs_n = 1'b0;
    idle(4);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    idle(12);
    checks++;
    if (n_pix !== 1 || xq.size() != 1 || xq[0] !== 16'h1234) begin
      errors++;
      $display("FAIL abort_pixel: got %0d pixels required one 1234", n_pix);
    end
    checks++;
    if (bq.size() !== 4) begin
      errors++;
      $display("FAIL abort_bytes: got %0d required 4", bq.size());
    end
    checks++;
    if (pix_count !== 17'd1 || cmd_code !== 8'h2C) begin
      errors++;
      $display("FAIL abort_hold: got cnt=%0d cmd=%0h required 1/2c",
               pix_count, cmd_code);
    end
  endtask

  task automatic test_state_bits();
    clear_mon();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h29, 1'b0, 1'b0);
    idle(12);
    checks++;
    if (sleep_out !== 1'b1 || disp_on !== 1'b1) begin
      errors++;
      $display("FAIL state_on: got sleep=%0b disp=%0b required 1/1",
               sleep_out, disp_on);
    end
    send_byte(8'h28, 1'b0, 1'b0);
    idle(12);
    checks++;
    if (sleep_out !== 1'b1 || disp_on !== 1'b0) begin
      errors++;
      $display("FAIL state_off: got sleep=%0b disp=%0b required 1/0",
               sleep_out, disp_on);
    end
    checks++;
    if (n_cmd !== 3) begin
      errors++;
      $display("FAIL state_cmds: got %0d required 3", n_cmd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h81;
    clear_mon();
    send_byte(exp_b[0], 1'b1, 1'b0);
    send_byte(exp_b[1], 1'b1, 1'b0);
    send_byte(exp_b[2], 1'b1, 1'b1);
    idle(12);
    checks++;
    if (bq.size() !== 3 || n_param !== 3) begin
      errors++;
      $display("FAIL b2b_count: got bytes=%0d params=%0d required 3/3",
               bq.size(), n_param);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < bq.size() && i < rq.size() && i < piq.size()) begin
        checks++;
        if (bq[i] !== exp_b[i] || bdq[i] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %0h dc=%0b required %0h dc=1",
                   i, bq[i], bdq[i], exp_b[i]);
        end
        checks++;
        if (bcq[i] - rq[i] !== SYNC + 2) begin
          errors++;
          $display("FAIL b2b_latency[%0d]: got %0d required %0d",
                   i, bcq[i] - rq[i], SYNC + 2);
        end
        checks++;
        if (piq[i] !== 4'(i)) begin
          errors++;
          $display("FAIL b2b_idx[%0d]: got %0d required %0d", i, piq[i], i);
        end
      end
    end
    spi.cs_n = 1'b0;
    idle(4);
  endtask

  initial begin
    spi.sck = 1'b0; spi.cs_n = 1'b1;
    spi.dc = 1'b0; spi.mosi = 1'b0;
    n_cmd = 0; n_param = 0; n_pix = 0;
    test_reset();
    test_params();
    test_pixels();
    test_cs_abort();
    test_state_bits();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
